// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared definitions for the JESD204 TPL DAC channel sample source.
// Holds the source-select encodings, the PN polynomial parameters and seeds,
// and the sample width used to slice the per-channel data bus.
package ad_ip_jesd204_tpl_dac_pkg;

  localparam int SAMPLE_WIDTH = 16;

  localparam logic [3:0] SEL_CONST = 4'd0;
  localparam logic [3:0] SEL_RAMP  = 4'd1;
  localparam logic [3:0] SEL_PN7   = 4'd2;
  localparam logic [3:0] SEL_PN15  = 4'd3;
  localparam logic [3:0] SEL_DMA   = 4'd4;

  // x^7 + x^6 + 1
  localparam int         PN7_WIDTH  = 7;
  localparam int         PN7_TAP    = 6;
  localparam logic [6:0] PN7_SEED   = 7'h7F;

  // x^15 + x^14 + 1
  localparam int          PN15_WIDTH = 15;
  localparam int          PN15_TAP   = 14;
  localparam logic [14:0] PN15_SEED  = 15'h7FFF;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_pn.sv
// Parallel Fibonacci LFSR producing OUT_W bits per clock, MSB-first per sample.
// Latency: output is combinational from the current (or seed) state; state updates on advance.
// Backpressure: none; the generator only steps when advance_i is high.
module ad_ip_jesd204_tpl_dac_pn
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int                POLY_W = 7,
  parameter int                TAP    = 6,
  parameter int                OUT_W  = 64,
  parameter logic [POLY_W-1:0] SEED   = '1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             advance_i,
  output logic [OUT_W-1:0] pn_o
);

  logic [POLY_W-1:0] state_q;
  logic [POLY_W-1:0] state_d;

  // Unroll OUT_W serial steps; a load restarts this very word from the seed.
  always_comb begin
    logic [POLY_W-1:0] s;
    logic              fb;
    pn_o = '0;
    fb   = 1'b0;
    s    = load_i ? SEED : state_q;
    for (int k = 0; k < OUT_W; k++) begin
      fb = s[POLY_W-1] ^ s[TAP-1];
      pn_o[SAMPLE_WIDTH*(k/SAMPLE_WIDTH) + (SAMPLE_WIDTH-1) - (k%SAMPLE_WIDTH)] = fb;
      s = {s[POLY_W-2:0], fb};
    end
    state_d = advance_i ? s : state_q;
  end

  // State register, seeded to all-ones on reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_channel_src.sv
// Per-channel DAC sample source: const, ramp, PN7, PN15 or DMA into the framer.
// Latency: one register stage from select/enable/DMA inputs to dac_data_o.
// Backpressure: dma_ready_o high whenever DMA is selected and enabled; a missing word is an underflow.
module ad_ip_jesd204_tpl_dac_channel_src
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    dac_enable_i,
  input  logic [3:0]                              dac_sel_i,
  input  logic [SAMPLE_WIDTH-1:0]                 dac_pat_const_i,
  input  logic [DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] dma_data_i,
  input  logic                                    dma_valid_i,
  output logic                                    dma_ready_o,
  output logic [DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] dac_data_o,
  output logic                                    dac_underflow_o,
  output logic [15:0]                             underflow_count_o
);

  localparam int W = DATA_PATH_WIDTH * SAMPLE_WIDTH;

  logic [3:0]              sel_prev_q;
  logic                    en_prev_q;
  logic [SAMPLE_WIDTH-1:0] ramp_base_q, ramp_base_d, ramp_start;
  logic [W-1:0]            ramp_word;
  logic [W-1:0]            pn7_word, pn15_word;
  logic [W-1:0]            dac_data_q, dac_data_d;
  logic                    underflow_q, underflow_d;
  logic [15:0]             count_q, count_d;
  logic                    reload;
  logic                    ramp_adv, pn7_adv, pn15_adv;

  // A fresh selection or a rising enable restarts the chosen generator in the same word.
  assign reload   = (dac_sel_i != sel_prev_q) || (dac_enable_i && !en_prev_q);
  assign ramp_adv = dac_enable_i && (dac_sel_i == SEL_RAMP);
  assign pn7_adv  = dac_enable_i && (dac_sel_i == SEL_PN7);
  assign pn15_adv = dac_enable_i && (dac_sel_i == SEL_PN15);

  assign dma_ready_o = dac_enable_i && (dac_sel_i == SEL_DMA) && !reset_i;

  // Ramp samples are base+n; base only moves while the ramp is the live source.
  always_comb begin
    ramp_word   = '0;
    ramp_start  = reload ? '0 : ramp_base_q;
    for (int n = 0; n < DATA_PATH_WIDTH; n++) begin
      ramp_word[n*SAMPLE_WIDTH +: SAMPLE_WIDTH] = ramp_start + SAMPLE_WIDTH'(n);
    end
    ramp_base_d = ramp_adv ? ramp_start + SAMPLE_WIDTH'(DATA_PATH_WIDTH) : ramp_base_q;
  end

  ad_ip_jesd204_tpl_dac_pn #(
    .POLY_W (PN7_WIDTH),
    .TAP    (PN7_TAP),
    .OUT_W  (W),
    .SEED   (PN7_SEED)
  ) u_pn7 (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (pn7_adv && reload),
    .advance_i (pn7_adv),
    .pn_o      (pn7_word)
  );

  ad_ip_jesd204_tpl_dac_pn #(
    .POLY_W (PN15_WIDTH),
    .TAP    (PN15_TAP),
    .OUT_W  (W),
    .SEED   (PN15_SEED)
  ) u_pn15 (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (pn15_adv && reload),
    .advance_i (pn15_adv),
    .pn_o      (pn15_word)
  );

  // Source mux; disabled or unknown selects drive zeros and never flag underflow.
  always_comb begin
    dac_data_d  = '0;
    underflow_d = 1'b0;
    if (dac_enable_i) begin
      case (dac_sel_i)
        SEL_CONST: dac_data_d = {DATA_PATH_WIDTH{dac_pat_const_i}};
        SEL_RAMP:  dac_data_d = ramp_word;
        SEL_PN7:   dac_data_d = pn7_word;
        SEL_PN15:  dac_data_d = pn15_word;
        SEL_DMA: begin
          if (dma_valid_i) begin
            dac_data_d = dma_data_i;
          end else begin
            underflow_d = 1'b1;
          end
        end
        default: dac_data_d = '0;
      endcase
    end
    count_d = (underflow_d && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
  end

  // Output, underflow and history registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dac_data_q  <= '0;
      underflow_q <= 1'b0;
      count_q     <= '0;
      sel_prev_q  <= SEL_CONST;
      en_prev_q   <= 1'b0;
      ramp_base_q <= '0;
    end else begin
      dac_data_q  <= dac_data_d;
      underflow_q <= underflow_d;
      count_q     <= count_d;
      sel_prev_q  <= dac_sel_i;
      en_prev_q   <= dac_enable_i;
      ramp_base_q <= ramp_base_d;
    end
  end

  assign dac_data_o        = dac_data_q;
  assign dac_underflow_o   = underflow_q;
  assign underflow_count_o = count_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_channel_src.sv
// Directed self-checking bench for the JESD204 TPL DAC channel sample source.
module tb_ad_ip_jesd204_tpl_dac_channel_src;

  localparam int DPW = 4;
  localparam int W   = DPW * 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         dac_enable;
  logic [3:0]   dac_sel;
  logic [15:0]  dac_pat_const;
  logic [W-1:0] dma_data;
  logic         dma_valid;
  logic         dma_ready;
  logic [W-1:0] dac_data;
  logic         dac_underflow;
  logic [15:0]  underflow_count;

  int checks_cnt = 0;
  int err_cnt    = 0;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_channel_src #(.DATA_PATH_WIDTH(DPW)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .dac_enable_i      (dac_enable),
    .dac_sel_i         (dac_sel),
    .dac_pat_const_i   (dac_pat_const),
    .dma_data_i        (dma_data),
    .dma_valid_i       (dma_valid),
    .dma_ready_o       (dma_ready),
    .dac_data_o        (dac_data),
    .dac_underflow_o   (dac_underflow),
    .underflow_count_o (underflow_count)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ramp_word(input logic [15:0] base);
    logic [W-1:0] w;
    w = '0;
    for (int n = 0; n < DPW; n++) w[n*16 +: 16] = base + 16'(n);
    return w;
  endfunction

  // Serial reference: out = s[msb]^s[msb-1], shift left inserting out; first bit -> bit 15 of sample 0.
  function automatic logic [W-1:0] pn_model(input int pw, input logic [14:0] st_in,
                                            output logic [14:0] st_out);
    logic [14:0]  st;
    logic [14:0]  mask;
    logic         b;
    logic [W-1:0] w;
    st   = st_in;
    mask = 15'((1 << pw) - 1);
    w    = '0;
    for (int k = 0; k < W; k++) begin
      b = st[pw-1] ^ st[pw-2];
      w[16*(k/16) + 15 - (k%16)] = b;
      st = ((st << 1) | {14'd0, b}) & mask;
    end
    st_out = st;
    return w;
  endfunction

  initial begin
    logic [14:0]  st;
    logic [W-1:0] exp_w;
    logic [9:0]   vpat;
    int           bad;

    reset = 1'b1; dac_enable = 1'b0; dac_sel = 4'd0; dac_pat_const = 16'h0;
    dma_data = '0; dma_valid = 1'b0;
    #2;
    chk("rst_data", dac_data, 64'h0);
    chk("rst_underflow", {63'd0, dac_underflow}, 64'h0);
    chk("rst_count", {48'd0, underflow_count}, 64'h0);
    dac_enable = 1'b1; dac_sel = 4'd4; dma_valid = 1'b1;
    #1;
    chk("rst_ready_gated", {63'd0, dma_ready}, 64'h0);
    dac_enable = 1'b0; dac_sel = 4'd0; dma_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Constant pattern
    dac_enable = 1'b1; dac_sel = 4'd0; dac_pat_const = 16'hA5C3;
    #1;
    chk("const_ready", {63'd0, dma_ready}, 64'h0);
    tick();
    chk("const_word0", dac_data, 64'hA5C3_A5C3_A5C3_A5C3);
    dac_pat_const = 16'h1234;
    tick();
    chk("const_word1", dac_data, 64'h1234_1234_1234_1234);

    // Ramp across the 16-bit wrap
    dac_sel = 4'd1;
    bad = 0;
    for (int k = 0; k <= 16384; k++) begin
      tick();
      exp_w = ramp_word(16'(4 * k));
      if (dac_data !== exp_w) bad++;
      if (k == 0)     chk("ramp_first", dac_data, 64'h0003_0002_0001_0000);
      if (k == 1)     chk("ramp_second", dac_data, 64'h0007_0006_0005_0004);
      if (k == 16383) chk("ramp_top", dac_data, 64'hFFFF_FFFE_FFFD_FFFC);
      if (k == 16384) chk("ramp_wrap", dac_data, 64'h0003_0002_0001_0000);
    end
    chk("ramp_stream_bad", 64'(bad), 64'h0);
    dac_sel = 4'd0;
    tick();
    dac_sel = 4'd1;
    tick();
    chk("ramp_restart", dac_data, 64'h0003_0002_0001_0000);
    tick();
    chk("ramp_restart_next", dac_data, 64'h0007_0006_0005_0004);

    // PN7
    dac_sel = 4'd2;
    st = 15'h7F;
    tick();
    exp_w = pn_model(7, st, st);
    chk("pn7_sample0", {48'd0, dac_data[15:0]}, 64'h020C);
    chk("pn7_word0", dac_data, exp_w);
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      exp_w = pn_model(7, st, st);
      if (dac_data !== exp_w) bad++;
    end
    chk("pn7_stream_bad", 64'(bad), 64'h0);
    dac_sel = 4'd0;
    tick();
    dac_sel = 4'd2;
    tick();
    chk("pn7_restart", {48'd0, dac_data[15:0]}, 64'h020C);

    // DMA with three underflow cycles
    dac_sel = 4'd4;
    vpat = 10'b10_1110_1011;
    for (int i = 0; i < 10; i++) begin
      dma_data  = 64'h0123_4567_89AB_0000 + 64'(i);
      dma_valid = vpat[i];
      #1;
      chk("dma_ready", {63'd0, dma_ready}, 64'h1);
      tick();
      chk("dma_data", dac_data, vpat[i] ? 64'h0123_4567_89AB_0000 + 64'(i) : 64'h0);
      chk("dma_underflow", {63'd0, dac_underflow}, {63'd0, ~vpat[i]});
    end
    chk("dma_count", {48'd0, underflow_count}, 64'd3);

    // Disabled and unknown selects
    dac_enable = 1'b0; dac_sel = 4'd4; dma_valid = 1'b1;
    #1;
    chk("dis_ready", {63'd0, dma_ready}, 64'h0);
    tick();
    chk("dis_data", dac_data, 64'h0);
    chk("dis_underflow", {63'd0, dac_underflow}, 64'h0);
    dac_enable = 1'b1; dac_sel = 4'd7;
    #1;
    chk("sel7_ready", {63'd0, dma_ready}, 64'h0);
    tick();
    chk("sel7_data", dac_data, 64'h0);
    chk("sel7_underflow", {63'd0, dac_underflow}, 64'h0);
    chk("sel7_count", {48'd0, underflow_count}, 64'd3);
    dma_valid = 1'b0;

    // PN15 restarts from seed on re-enable
    dac_enable = 1'b0; dac_sel = 4'd3;
    tick();
    chk("pn15_off", dac_data, 64'h0);
    dac_enable = 1'b1;
    st = 15'h7FFF;
    tick();
    exp_w = pn_model(15, st, st);
    chk("pn15_sample0", {48'd0, dac_data[15:0]}, 64'h0002);
    chk("pn15_word0", dac_data, exp_w);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_w = pn_model(15, st, st);
      if (dac_data !== exp_w) bad++;
    end
    chk("pn15_stream_bad", 64'(bad), 64'h0);
    dac_enable = 1'b0;
    tick();
    dac_enable = 1'b1;
    st = 15'h7FFF;
    tick();
    exp_w = pn_model(15, st, st);
    chk("pn15_reenable", dac_data, exp_w);

    // Asynchronous reset in the middle of a cycle
    tick();
    exp_w = pn_model(15, st, st);
    chk("pn15_pre_reset", dac_data, exp_w);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_data", dac_data, 64'h0);
    chk("arst_count", {48'd0, underflow_count}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    st = 15'h7FFF;
    tick();
    exp_w = pn_model(15, st, st);
    chk("post_reset_word0", dac_data, exp_w);
    tick();
    exp_w = pn_model(15, st, st);
    chk("post_reset_word1", dac_data, exp_w);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_channel_src.md
Name: ad_ip_jesd204_tpl_dac_channel_src

Overview:
Per-channel sample source for the JESD204 transmit transport layer. It produces DATA_PATH_WIDTH 16-bit samples per clock and feeds the channel's slice of dac_data into the framer. It selects between a constant, a ramp, a PN7 sequence, a PN15 sequence and DMA data, and the DMA input uses a valid/ready handshake with underflow reporting. One instance is used per converter channel.

Parameters:
DATA_PATH_WIDTH, 4, samples per clock per channel; each sample is 16 bits, so the data bus width W = DATA_PATH_WIDTH*16.

Ports:
clk  input  1  link-side clock (line-rate/40). Single clock domain.
reset  input  1  asynchronous, active-high reset.
dac_enable  input  1  channel enable; when 0, the output is all zeros.
dac_sel  input  4  source select: 0 = const, 1 = ramp, 2 = PN7, 3 = PN15, 4 = DMA; any other value = zeros.
dac_pat_const  input  16  constant pattern value.
dma_data  input  W  DMA samples, sample 0 in bits [15:0].
dma_valid  input  1  DMA word valid.
dma_ready  output  1  word accepted when dma_valid && dma_ready.
dac_data  output  W  registered samples to the framer, sample n in bits [16n+15:16n].
dac_underflow  output  1  one-cycle pulse when DMA data was required but not present.
underflow_count  output  16  saturating count of underflow cycles.

Behaviour:
- Reset (asynchronous, active-high):
  - dac_data = 0, dac_underflow = 0, underflow_count = 0, dma_ready = 0.
  - PN7 state and PN15 state = all-ones; ramp base = 0; sel_d = 0; enable_d = 0.
- Latency: dac_sel, dac_enable and dma_data sampled at edge t appear on dac_data after edge t (1-cycle register stage). There is no other pipelining.
- Reload condition R = (dac_sel != sel_d) || (dac_enable && !enable_d). sel_d and enable_d are the previous-cycle registered copies.
  - When R holds, the newly selected generator emits from its seed in that same output word: ramp starts at 0, PN starts at all-ones.
- Generators advance only in cycles where they are selected and dac_enable = 1. Otherwise they hold their state.
- Const: every sample = dac_pat_const. A change takes effect on the next output word.
- Ramp: sample n = base + n (mod 2^16); base += DATA_PATH_WIDTH each cycle, wrapping at 16 bits.
- PN7 (x^7+x^6+1) and PN15 (x^15+x^14+1) bit generation:
  - Serial-equivalent rule: out = s[MSB] ^ s[MSB-1], then s = {s[MSB-1:0], out}.
  - W bits are produced per clock. The first bit generated goes to bit 15 of sample 0, continuing MSB-first through sample 0, then sample 1, and so on.
  - The state after W steps is carried to the next cycle.
- DMA handshake:
  - dma_ready = dac_enable && dac_sel == 4 && !reset, combinational from registered-free inputs.
  - Handshake true: dac_data <= dma_data.
  - dma_ready = 1 but dma_valid = 0: dac_data <= 0, dac_underflow <= 1, and underflow_count increments, saturating at 0xFFFF.
  - dma_valid while dma_ready = 0 is ignored and nothing is consumed.
- dac_enable = 0: dac_data <= 0, no underflow is reported, and generators hold.
- Unknown dac_sel values: dac_data <= 0, no underflow, dma_ready = 0.
- Reset mid-operation: outputs clear immediately and asynchronously. The first word after release follows the reload rule; sel_d = 0, so selecting const needs no reload.
- underflow_count clears only on reset.

Decomposition:
- Shared package ad_ip_jesd204_tpl_dac_pkg holds:
  - select encodings (SEL_CONST = 0, SEL_RAMP = 1, SEL_PN7 = 2, SEL_PN15 = 3, SEL_DMA = 4);
  - the PN7/PN15 polynomial taps and all-ones seeds;
  - SAMPLE_WIDTH = 16.
- Sub-module ad_ip_jesd204_tpl_dac_pn: a parallel LFSR unrolled W steps per clock, parameterized by polynomial width and tap. It has load and advance inputs, a W-bit output and a state register. It is instantiated twice, once for PN7 and once for PN15.

Test Plan:
- Const: enable = 1, sel = 0, const = 0xA5C3, DATA_PATH_WIDTH = 4 -> from the 2nd edge, every sample = 0xA5C3 and dma_ready = 0.
- Ramp wrap: sel = 1 held for 16385 cycles -> first word is 0,1,2,3, second is 4,5,6,7; the word after base 0xFFFC is 0,1,2,3. Switching to sel = 0 and back restarts at 0,1,2,3.
- PN7: sel = 2 from reset -> sample 0 of the first word = 0x020C. The full stream matches the serial reference model over 200 cycles, and reselecting restarts at 0x020C.
- DMA underflow: sel = 4 with dma_valid low for 3 of 10 cycles -> dac_data = 0 on exactly those 3 words, dac_underflow pulses 3 times, and underflow_count = 3. Accepted words appear 1 cycle after the handshake.
- Disable/unknown select: enable = 0 or sel = 7 with dma_valid = 1 -> dac_data = 0, dma_ready = 0, no underflow. On re-enable with PN15, the sequence restarts from seed.
- Reset mid-stream: assert reset asynchronously between edges during PN15 -> dac_data and underflow_count read 0 immediately. After release, the PN15 output equals the from-seed model.
